// File: rtl/seven_segment_scan_controller.sv
// Scans a 4-digit common-anode seven-segment display with a blanking gap
// before each digit; new words are committed only at frame boundaries.
module seven_segment_scan_controller #(
    parameter int BLANK_CYCLES = 2,
    parameter int DRIVE_CYCLES = 25000
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic [15:0] digit_data_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    input  logic [3:0]  blank_mask_i,
    input  logic        display_en_i,
    output logic [3:0]  digital_select_o,
    output logic [6:0]  seven_bit_display_o,
    output logic        frame_done_o
);

    localparam int MAX_CYCLES =
        (BLANK_CYCLES > DRIVE_CYCLES) ? BLANK_CYCLES : DRIVE_CYCLES;
    localparam int CNT_W =
        (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] DRIVE_LAST = CNT_W'(DRIVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    typedef enum logic {
        BLANK,
        DRIVE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       digit_idx_q, digit_idx_d;
    logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
    logic [15:0]      active_word_q, active_word_d;
    logic [15:0]      pending_word_q, pending_word_d;
    logic             pending_full_q, pending_full_d;
    logic             commit;
    logic             accept;
    logic [3:0]       nibble;
    logic [3:0]       sel_q, sel_d;
    logic [6:0]       seg_q, seg_d;
    logic             frame_done_q;

    function automatic logic [6:0] hexdec(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        state_d     = state_q;
        slot_cnt_d  = slot_cnt_q + CNT_ONE;
        digit_idx_d = digit_idx_q;
        commit      = 1'b0;
        unique case (state_q)
            BLANK: begin
                if (slot_cnt_q == BLANK_LAST) begin
                    state_d    = DRIVE;
                    slot_cnt_d = '0;
                end
            end
            DRIVE: begin
                if (slot_cnt_q == DRIVE_LAST) begin
                    state_d     = BLANK;
                    slot_cnt_d  = '0;
                    digit_idx_d = digit_idx_q + 2'd1;
                    commit      = (digit_idx_q == 2'd3);
                end
            end
        endcase
    end

    // Accept is only possible with the slot empty, so it never collides
    // with a commit of the same pending word.
    always_comb begin
        accept         = data_valid_i && !pending_full_q;
        pending_full_d = pending_full_q;
        pending_word_d = pending_word_q;
        active_word_d  = active_word_q;
        if (commit && pending_full_q) begin
            active_word_d  = pending_word_q;
            pending_full_d = 1'b0;
        end
        if (accept) begin
            pending_word_d = digit_data_i;
            pending_full_d = 1'b1;
        end
    end

    // Outputs are registered from next-state values so they line up
    // with the state held in the same cycle.
    always_comb begin
        nibble = active_word_d[{digit_idx_d, 2'b00} +: 4];
        sel_d  = 4'b1111;
        seg_d  = 7'h7F;
        if (state_d == DRIVE && display_en_i &&
            !blank_mask_i[digit_idx_d]) begin
            sel_d = ~(4'b0001 << digit_idx_d);
            seg_d = hexdec(nibble);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q        <= BLANK;
            digit_idx_q    <= 2'd0;
            slot_cnt_q     <= '0;
            active_word_q  <= 16'h0000;
            pending_word_q <= 16'h0000;
            pending_full_q <= 1'b0;
            sel_q          <= 4'b1111;
            seg_q          <= 7'h7F;
            frame_done_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            digit_idx_q    <= digit_idx_d;
            slot_cnt_q     <= slot_cnt_d;
            active_word_q  <= active_word_d;
            pending_word_q <= pending_word_d;
            pending_full_q <= pending_full_d;
            sel_q          <= sel_d;
            seg_q          <= seg_d;
            frame_done_q   <= commit;
        end
    end

    assign data_ready_o        = ~pending_full_q;
    assign digital_select_o    = sel_q;
    assign seven_bit_display_o = seg_q;
    assign frame_done_o        = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Bench for seven_segment_scan_controller: per-frame expectations are
// queued by the stimulus and checked by a negedge frame monitor.
module tb_seven_segment_scan_controller;

    localparam int BC    = 2;
    localparam int DC    = 4;
    localparam int SLOT  = BC + DC;
    localparam int FRAME = 4 * SLOT;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] digit_data = 16'h0000;
    logic        data_valid = 1'b0;
    logic        data_ready;
    logic [3:0]  blank_mask = 4'h0;
    logic        display_en = 1'b1;
    logic [3:0]  sel;
    logic [6:0]  seg;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [3:0]  lit;
        logic [27:0] segs;
    } exp_t;

    exp_t exp_q[$];

    seven_segment_scan_controller #(
        .BLANK_CYCLES(BC),
        .DRIVE_CYCLES(DC)
    ) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .digit_data_i       (digit_data),
        .data_valid_i       (data_valid),
        .data_ready_o       (data_ready),
        .blank_mask_i       (blank_mask),
        .display_en_i       (display_en),
        .digital_select_o   (sel),
        .seven_bit_display_o(seg),
        .frame_done_o       (frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, got, want, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;  4'h1: s = 7'h79;
            4'h2: s = 7'h24;  4'h3: s = 7'h30;
            4'h4: s = 7'h19;  4'h5: s = 7'h12;
            4'h6: s = 7'h02;  4'h7: s = 7'h78;
            4'h8: s = 7'h00;  4'h9: s = 7'h10;
            4'hA: s = 7'h08;  4'hB: s = 7'h03;
            4'hC: s = 7'h46;  4'hD: s = 7'h21;
            4'hE: s = 7'h06;  default: s = 7'h0E;
        endcase
        return s;
    endfunction

    function automatic exp_t mk(input logic [15:0] w,
                                input logic [3:0] mask,
                                input logic en);
        exp_t e;
        e.lit = en ? ~mask : 4'h0;
        e.segs = '0;
        for (int k = 0; k < 4; k++)
            e.segs[7*k +: 7] = seg_of(w[4*k +: 4]);
        return e;
    endfunction

    // Frame monitor
    int         fcnt = 0;
    int         lit_cnt[4];
    int         first_pos[4];
    logic [6:0] seg_obs[4];

    task automatic clear_acc();
        for (int k = 0; k < 4; k++) begin
            lit_cnt[k] = 0;
            first_pos[k] = -1;
            seg_obs[k] = 7'h7F;
        end
    endtask

    task automatic eval_frame();
        exp_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected: no expectation at %0t", $time);
        end else begin
            e = exp_q.pop_front();
            chk("frame_len", fcnt, FRAME);
            for (int k = 0; k < 4; k++) begin
                if (e.lit[k]) begin
                    chk($sformatf("lit_cnt%0d", k), lit_cnt[k], DC);
                    chk($sformatf("lit_pos%0d", k), first_pos[k],
                        k * SLOT + BC);
                    chk($sformatf("seg%0d", k), {25'd0, seg_obs[k]},
                        {25'd0, e.segs[7*k +: 7]});
                end else begin
                    chk($sformatf("dark%0d", k), lit_cnt[k], 0);
                end
            end
        end
    endtask

    initial clear_acc();

    always @(negedge clk) begin
        int k;
        if (!reset_n) begin
            chk("rst_sel", sel, 4'hF);
            chk("rst_seg", seg, 7'h7F);
            chk("rst_fd", frame_done, 1'b0);
            chk("rst_ready", data_ready, 1'b1);
            fcnt = 0;
            clear_acc();
        end else begin
            if (frame_done) begin
                eval_frame();
                clear_acc();
                fcnt = 0;
            end
            if (sel == 4'hF) begin
                chk("off_seg", seg, 7'h7F);
            end else begin
                case (sel)
                    4'b1110: k = 0;
                    4'b1101: k = 1;
                    4'b1011: k = 2;
                    4'b0111: k = 3;
                    default: k = -1;
                endcase
                if (k < 0) begin
                    chk("one_cold", sel, 4'hE);
                end else begin
                    if (lit_cnt[k] == 0)
                        first_pos[k] = fcnt;
                    else
                        chk("seg_stable", seg, seg_obs[k]);
                    seg_obs[k] = seg;
                    lit_cnt[k]++;
                end
            end
            fcnt++;
        end
    end

    // Stimulus
    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fd();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!frame_done && n < 40);
        chk("frame_timeout", frame_done, 1'b1);
    endtask

    task automatic send(input logic [15:0] w);
        digit_data = w;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        chk("ready_drop", data_ready, 1'b0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
    endtask

    initial begin
        int n;
        wait_neg(3);
        // idle frames after reset
        exp_q.push_back(mk(16'h0000, 4'h0, 1'b1));
        release_reset();
        chk("ready_after_rst", data_ready, 1'b1);
        wait_fd();
        exp_q.push_back(mk(16'h0000, 4'h0, 1'b1));
        wait_fd();

        // mid-frame push, committed at frame end
        exp_q.push_back(mk(16'h0000, 4'h0, 1'b1));
        wait_neg(8);
        send(16'h3A0F);
        wait_fd();
        chk("ready_return", data_ready, 1'b1);
        exp_q.push_back(mk(16'h3A0F, 4'h0, 1'b1));
        wait_fd();

        // second word held while not ready
        exp_q.push_back(mk(16'h3A0F, 4'h0, 1'b1));
        wait_neg(5);
        send(16'h1111);
        digit_data = 16'h2222;
        data_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_ready && n < 40);
        chk("hold_ready", data_ready, 1'b1);
        chk("hold_at_fd", frame_done, 1'b1);
        exp_q.push_back(mk(16'h1111, 4'h0, 1'b1));
        @(negedge clk);
        data_valid = 1'b0;
        chk("hold_taken", data_ready, 1'b0);
        wait_fd();
        exp_q.push_back(mk(16'h2222, 4'h0, 1'b1));
        wait_fd();

        // mask and display enable
        exp_q.push_back(mk(16'h2222, 4'b0100, 1'b1));
        blank_mask = 4'b0100;
        wait_fd();
        exp_q.push_back(mk(16'h2222, 4'h0, 1'b0));
        blank_mask = 4'h0;
        display_en = 1'b0;
        wait_fd();

        // accept exactly on the commit cycle
        exp_q.push_back(mk(16'h2222, 4'h0, 1'b1));
        display_en = 1'b1;
        wait_neg(FRAME - 1);
        digit_data = 16'hBCDE;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        chk("commit_edge_fd", frame_done, 1'b1);
        chk("commit_edge_rdy", data_ready, 1'b0);
        exp_q.push_back(mk(16'h2222, 4'h0, 1'b1));
        wait_fd();
        exp_q.push_back(mk(16'hBCDE, 4'h0, 1'b1));
        wait_fd();

        // reset mid digit-2 drive with a pending word
        exp_q.push_back(mk(16'hBCDE, 4'h0, 1'b1));
        wait_neg(3);
        send(16'h4567);
        wait_neg(11);
        #2 reset_n = 1'b0;
        #1;
        chk("async_sel", sel, 4'hF);
        chk("async_seg", seg, 7'h7F);
        chk("async_ready", data_ready, 1'b1);
        exp_q.delete();
        wait_neg(3);
        exp_q.push_back(mk(16'h0000, 4'h0, 1'b1));
        release_reset();
        wait_fd();

        // remaining digits
        exp_q.push_back(mk(16'h0000, 4'h0, 1'b1));
        wait_neg(4);
        send(16'h4567);
        wait_fd();
        exp_q.push_back(mk(16'h4567, 4'h0, 1'b1));
        wait_neg(4);
        send(16'h9876);
        wait_fd();
        exp_q.push_back(mk(16'h9876, 4'h0, 1'b1));
        wait_fd();

        wait_neg(3);
        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
